demxuong4b: RTL and testbench

DEMXUONG4B -- requirements
Module: demxuong4b

---
 rtl/demxuong4b.sv | 55 +++++
 tb/tb_demxuong4b.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demxuong4b.sv
// rtl/demxuong4b.sv - prescaled 4-bit down counter with parallel load and wrap pulse
module demxuong4b #(
    parameter int DIV      = 4,
    parameter int WRAP_VAL = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] din,
    output logic [3:0] Q,
    output logic       tc,
    output logic       zero
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] DIV_LAST = W'(DIV - 1);
    localparam logic [3:0]   WRAP     = 4'(WRAP_VAL);

    logic [W-1:0] div_cnt;
    logic         step;

    assign step = (div_cnt == DIV_LAST);
    assign zero = (Q == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            Q       <= WRAP;
            div_cnt <= '0;
            tc      <= 1'b0;
        end else if (load) begin
            Q       <= din;
            div_cnt <= '0;
            tc      <= 1'b0;
        end else if (en) begin
            if (step) begin
                div_cnt <= '0;
                // Only the 0 -> WRAP_VAL transition reloads; loaded values above it count down normally
                if (Q == 4'd0) begin
                    Q  <= WRAP;
                    tc <= 1'b1;
                end else begin
                    Q  <= Q - 4'd1;
                    tc <= 1'b0;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
                tc      <= 1'b0;
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_demxuong4b.sv
// tb/tb_demxuong4b.sv - self-checking bench for demxuong4b (default and DIV=1/WRAP_VAL=9 instances)
module tb_demxuong4b;

    logic       clk;
    logic       reset;
    logic       en;
    logic       load;
    logic [3:0] din;
    logic [3:0] q_a, q_b;
    logic       tc_a, tc_b, zero_a, zero_b;

    int total = 0;
    int bad   = 0;

    int ma_q, ma_ph, mb_q, mb_ph;
    bit ma_tc, mb_tc;

    demxuong4b dut_a (
        .clk(clk), .reset(reset), .en(en), .load(load), .din(din),
        .Q(q_a), .tc(tc_a), .zero(zero_a)
    );

    demxuong4b #(.DIV(1), .WRAP_VAL(9)) dut_b (
        .clk(clk), .reset(reset), .en(en), .load(load), .din(din),
        .Q(q_b), .tc(tc_b), .zero(zero_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a step happens after every div-th enabled cycle since the last step/load/reset
    task automatic model_step(inout int q, inout int ph, inout bit t, input int div, input int wrap);
        if (reset) begin
            q = wrap; ph = 0; t = 1'b0;
        end else if (load) begin
            q = int'(din); ph = 0; t = 1'b0;
        end else if (en) begin
            ph = ph + 1;
            t = 1'b0;
            if (ph == div) begin
                ph = 0;
                if (q == 0) begin
                    q = wrap; t = 1'b1;
                end else begin
                    q = q - 1;
                end
            end
        end else begin
            t = 1'b0;
        end
    endtask

    task automatic tick();
        model_step(ma_q, ma_ph, ma_tc, 4, 15);
        model_step(mb_q, mb_ph, mb_tc, 1, 9);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; load = 1'b0; din = 4'd0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; load = 1'b1; din = 4'($urandom_range(0, 15));
        tick();
        reset = 1'b0; load = 1'b0; en = 1'b0;
        total++;
        if (q_a !== 4'd15 || tc_a !== 1'b0 || zero_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_a: Q=%0d tc=%b zero=%b, need Q=15 tc=0 zero=0", q_a, tc_a, zero_a);
        end
        total++;
        if (q_b !== 4'd9 || tc_b !== 1'b0) begin
            bad++;
            $display("FAIL reset_b: Q=%0d tc=%b, need Q=9 tc=0", q_b, tc_b);
        end
    endtask

    task automatic test_full_cycle();
        int pulses;
        do_reset();
        en = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 130; k++) begin
            tick();
            if (tc_a === 1'b1) pulses++;
            total++;
            if (q_a !== 4'(ma_q) || tc_a !== ma_tc || zero_a !== (ma_q == 0)) begin
                bad++;
                $display("FAIL cycle_a k=%0d: Q=%0d tc=%b zero=%b, need Q=%0d tc=%b", k, q_a, tc_a, zero_a, ma_q, ma_tc);
            end
            if (k == 60 || k == 64) begin
                total++;
                if (q_a !== ((k == 60) ? 4'd0 : 4'd15) || tc_a !== (k == 64)) begin
                    bad++;
                    $display("FAIL wrap_point k=%0d: Q=%0d tc=%b", k, q_a, tc_a);
                end
            end
        end
        total++;
        if (pulses != 2) begin
            bad++;
            $display("FAIL tc_pulse_count: got %0d, need 2", pulses);
        end
        en = 1'b0;
    endtask

    task automatic test_load_mid();
        do_reset();
        en = 1'b1;
        tick(); tick();
        load = 1'b1; din = 4'd3;
        tick();
        load = 1'b0;
        total++;
        if (q_a !== 4'd3 || tc_a !== 1'b0) begin
            bad++;
            $display("FAIL load_mid: Q=%0d tc=%b, need Q=3 tc=0", q_a, tc_a);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++;
            if (q_a !== ((k == 4) ? 4'd2 : 4'd3)) begin
                bad++;
                $display("FAIL load_then_step k=%0d: Q=%0d need %0d", k, q_a, (k == 4) ? 2 : 3);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_pause();
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            total++;
            if (q_a !== 4'd14 || tc_a !== 1'b0) begin
                bad++;
                $display("FAIL pause_hold k=%0d: Q=%0d tc=%b, need Q=14", k, q_a, tc_a);
            end
        end
        en = 1'b1;
        tick();
        total++;
        if (q_a !== 4'd14) begin
            bad++;
            $display("FAIL resume_first: Q=%0d need 14", q_a);
        end
        tick();
        total++;
        if (q_a !== 4'd13) begin
            bad++;
            $display("FAIL resume_step: Q=%0d need 13", q_a);
        end
        en = 1'b0;
    endtask

    task automatic test_reset_over_load();
        do_reset();
        load = 1'b1; din = 4'd0;
        tick();
        load = 1'b0; en = 1'b1;
        tick(); tick(); tick();
        reset = 1'b1; load = 1'b1; din = 4'd5;
        tick();
        reset = 1'b0; load = 1'b0;
        total++;
        if (q_a !== 4'd15 || tc_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_over_load: Q=%0d tc=%b, need Q=15 tc=0", q_a, tc_a);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++;
            if (q_a !== ((k == 4) ? 4'd14 : 4'd15) || tc_a !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_prescale k=%0d: Q=%0d tc=%b", k, q_a, tc_a);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_wrap_div1();
        do_reset();
        en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            total++;
            if (q_b !== ((k < 10) ? 4'(9 - k) : 4'd9) || tc_b !== (k == 10)) begin
                bad++;
                $display("FAIL b_wrap k=%0d: Q=%0d tc=%b", k, q_b, tc_b);
            end
        end
        load = 1'b1; din = 4'd12;
        tick();
        load = 1'b0;
        total++;
        if (q_b !== 4'd12 || tc_b !== 1'b0) begin
            bad++;
            $display("FAIL b_load12: Q=%0d tc=%b, need 12", q_b, tc_b);
        end
        for (int k = 1; k <= 13; k++) begin
            tick();
            total++;
            if (q_b !== ((k < 13) ? 4'(12 - k) : 4'd9) || tc_b !== (k == 13) || zero_b !== (k == 12)) begin
                bad++;
                $display("FAIL b_above_wrap k=%0d: Q=%0d tc=%b zero=%b", k, q_b, tc_b, zero_b);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            reset = ($urandom_range(0, 63) == 0);
            load  = ($urandom_range(0, 15) == 0);
            en    = ($urandom_range(0, 3) != 0);
            din   = 4'($urandom_range(0, 15));
            tick();
            total++;
            if (q_a !== 4'(ma_q) || tc_a !== ma_tc || zero_a !== (ma_q == 0)) begin
                bad++;
                $display("FAIL rand_a k=%0d: Q=%0d tc=%b zero=%b, need Q=%0d tc=%b", k, q_a, tc_a, zero_a, ma_q, ma_tc);
            end
            total++;
            if (q_b !== 4'(mb_q) || tc_b !== mb_tc || zero_b !== (mb_q == 0)) begin
                bad++;
                $display("FAIL rand_b k=%0d: Q=%0d tc=%b zero=%b, need Q=%0d tc=%b", k, q_b, tc_b, zero_b, mb_q, mb_tc);
            end
        end
        reset = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; load = 1'b0; din = 4'd0;
        ma_q = 0; ma_ph = 0; ma_tc = 1'b0;
        mb_q = 0; mb_ph = 0; mb_tc = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_cycle();
        test_load_mid();
        test_pause();
        test_reset_over_load();
        test_wrap_div1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
